barrel_shift_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16-bit combinational left shifter.
- Supports four modes: shift-left, logical shift-right, arithmetic shift-right and rotate-left.
- Operands move through one register stage per shift-amount bit, so throughput is one result per clock.
- Handshake is valid/ready on both sides; the block sits between an operand source and the ALU result mux.

---
 rtl/barrel_shift_pipe_if.sv | 34 +++
 rtl/barrel_shift_pipe.sv | 159 +++++++++++++++
 tb/tb_barrel_shift_pipe.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shift_pipe_if.sv
// Valid/ready bus for the pipelined barrel shifter: the operand side
// (in_*) and the result side (out_*) travel together in one bundle.
// The master drives operands and consumes results; the slave is the shifter.
interface barrel_shift_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAGW  = 4
);
  localparam int SHW = $clog2(WIDTH);

  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_op;
  logic [TAGW-1:0]  in_tag;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic [TAGW-1:0]  out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_tag
  );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: SHL, logical SHR, arithmetic SHR and ROL.
// Stage k applies a shift of 2^k when amount bit k is set, so the pipe is
// log2(WIDTH) register stages deep and accepts one operation per clock.
// The pipe collapses bubbles: a stage refills whenever it is empty or its
// occupant moves on. The last stage's registers drive the result port
// directly, so a result is first seen by the consumer SHW edges after the
// operation was accepted. WIDTH must be a power of two, at least 4.
module barrel_shift_pipe #(
  parameter int WIDTH = 16,
  parameter int TAGW  = 4
) (
  input logic               clk,
  input logic               rst_n,
  barrel_shift_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // Each stage only forwards the amount bits later stages still need, so
  // the carried amount shrinks by one bit per stage. The fields are packed
  // back to back: stage k (k < SHW-1) owns SHW-1-k bits starting here.
  function automatic int amt_off(int k);
    return k * (SHW - 1) - (k * (k - 1)) / 2;
  endfunction

  localparam int AMT_BITS = (SHW * (SHW - 1)) / 2;

  logic [SHW-1:0]             w_valid;
  logic [SHW-1:0]             w_load;
  logic [SHW-1:0][WIDTH-1:0]  w_data;
  logic [SHW-1:0][TAGW-1:0]   w_tag;
  logic [SHW-2:0][1:0]        w_op;
  logic [AMT_BITS-1:0]        w_amt;
  logic                       w_zero;

  // Load enables, resolved from the output back towards the input.
  // NOTE: the whole vector gets a default first so no path through the loop
  // can leave a bit unassigned and infer a latch.
  always_comb begin
    w_load          = '0;
    w_load[SHW-1]   = !w_valid[SHW-1] | bus.out_ready;
    for (int k = SHW - 2; k >= 0; k--) begin
      w_load[k] = !w_valid[k] | w_load[k+1];
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int S  = 1 << k;   // shift distance applied by this stage
    localparam int IW = SHW - k;  // amount bits still pending on entry

    logic             w_in_valid;
    logic [WIDTH-1:0] w_in_data;
    logic [IW-1:0]    w_in_amt;
    logic [1:0]       w_in_op;
    logic [TAGW-1:0]  w_in_tag;
    logic [WIDTH-1:0] w_shifted;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [TAGW-1:0]  r_tag;

    if (k == 0) begin : g_src
      assign w_in_valid = bus.in_valid;
      assign w_in_data  = bus.in_data;
      assign w_in_amt   = bus.in_amt;
      assign w_in_op    = bus.in_op;
      assign w_in_tag   = bus.in_tag;
    end else begin : g_src
      assign w_in_valid = w_valid[k-1];
      assign w_in_data  = w_data[k-1];
      assign w_in_amt   = w_amt[amt_off(k-1) +: IW];
      assign w_in_op    = w_op[k-1];
      assign w_in_tag   = w_tag[k-1];
    end

    // Apply this stage's 2^k shift when the lowest pending amount bit is set.
    // For SRA the current MSB still equals the original sign at every stage.
    always_comb begin
      w_shifted = w_in_data;
      if (w_in_amt[0]) begin
        case (w_in_op)
          OP_SHL:  w_shifted = w_in_data << S;
          OP_SHR:  w_shifted = w_in_data >> S;
          OP_SRA:  w_shifted = $unsigned($signed(w_in_data) >>> S);
          OP_ROL:  w_shifted = (w_in_data << S) | (w_in_data >> (WIDTH - S));
          default: w_shifted = w_in_data;
        endcase
      end
    end

    // Stage register: valid follows every load; the payload only changes
    // when a real operation arrives, so a bubble leaves it untouched.
    // NOTE: the data and tag registers sit on the async reset as well, so the
    // result port reads zero the instant rst_n falls, not at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_tag   <= '0;
      end else if (w_load[k]) begin
        // NOTE: non-blocking updates let every stage sample its upstream
        // neighbour's old value on the same edge, which is what moves the pipe.
        r_valid <= w_in_valid;
        if (w_in_valid) begin
          r_data <= w_shifted;
          r_tag  <= w_in_tag;
        end
      end
    end

    assign w_valid[k] = r_valid;
    assign w_data[k]  = r_data;
    assign w_tag[k]   = r_tag;

    if (k < SHW - 1) begin : g_fwd
      logic [IW-2:0] r_amt;
      logic [1:0]    r_op;

      // Hand the still-unused amount bits and the mode on to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_amt <= '0;
          r_op  <= OP_SHL;
        end else if (w_load[k] && w_in_valid) begin
          r_amt <= w_in_amt[IW-1:1];
          r_op  <= w_in_op;
        end
      end

      assign w_amt[amt_off(k) +: IW-1] = r_amt;
      assign w_op[k]                   = r_op;
    end else begin : g_last
      logic r_zero;

      // Zero flag is registered alongside the final data word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_zero <= 1'b0;
        end else if (w_load[k] && w_in_valid) begin
          r_zero <= (w_shifted == '0);
        end
      end

      assign w_zero = r_zero;
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = w_valid[SHW-1];
  assign bus.out_data  = w_data[SHW-1];
  assign bus.out_tag   = w_tag[SHW-1];
  assign bus.out_zero  = w_zero;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH=16).
// A queue-based reference model predicts every result from plain
// double-width arithmetic; one negedge monitor compares the DUT against it.
module tb_barrel_shift_pipe;

  localparam int WIDTH = 16;
  localparam int TAGW  = 4;
  localparam int SHW   = 4;

  localparam logic [1:0] SHL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAGW-1:0]  tag;
  } exp_t;

  typedef struct {
    int               c;
    logic [WIDTH-1:0] d;
    logic [TAGW-1:0]  t;
    logic             z;
  } emit_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic saw_full = 1'b0;

  exp_t  exp_q[$];
  emit_t emit_q[$];

  barrel_shift_pipe_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

  barrel_shift_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: shift inside a double-width word, then pick the right half.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input int amt);
    logic [2*WIDTH-1:0] w;
    case (op)
      SHL: begin w = {{WIDTH{1'b0}}, a} << amt;     return w[WIDTH-1:0];       end
      SRL: begin w = {{WIDTH{1'b0}}, a} >> amt;     return w[WIDTH-1:0];       end
      SRA: begin w = {{WIDTH{a[WIDTH-1]}}, a} >> amt; return w[WIDTH-1:0];     end
      default: begin w = {a, a} << amt;             return w[2*WIDTH-1:WIDTH]; end
    endcase
  endfunction

  // Compare process: every settled cycle, check handshake and results.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", bus.in_ready, !(exp_q.size() == SHW && !bus.out_ready));
      if (!bus.in_ready) saw_full = 1'b1;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", bus.out_valid, 0);
        end else begin
          check("out_data", bus.out_data, exp_q[0].data);
          check("out_tag",  bus.out_tag,  exp_q[0].tag);
          check("out_zero", bus.out_zero, exp_q[0].data == '0);
        end
        if (bus.out_ready) begin
          emit_q.push_back('{cyc, bus.out_data, bus.out_tag, bus.out_zero});
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back('{ref_shift(bus.in_op, bus.in_data, int'(bus.in_amt)), bus.in_tag});
    end
  end

  // Present one operation and hold it until accepted; returns in the drive
  // phase (#1 after the accepting edge) with in_valid still high.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a,
                      input logic [SHW-1:0] amt, input logic [TAGW-1:0] tag,
                      output int acc);
    acc          = -1;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = a;
    bus.in_amt   = amt;
    bus.in_tag   = tag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = cyc;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", bus.in_ready, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_back_to_back(input string name, input int first_acc, input int n);
    check({name, "_count"}, emit_q.size(), n);
    if (emit_q.size() == n) begin
      check({name, "_lat"}, emit_q[0].c - first_acc, SHW);
      for (int i = 1; i < n; i++) check({name, "_gap"}, emit_q[i].c - emit_q[i-1].c, 1);
    end
  endtask

  initial begin
    int acc;
    int acc0;
    logic [1:0] op4[4];
    logic [WIDTH-1:0] a4[4];
    logic [SHW-1:0] amt4[4];
    logic [WIDTH-1:0] want4[4];
    logic done;

    // Operand offered while in reset must be ignored.
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hFFFF;
    bus.in_amt    = '0;
    bus.in_op     = SHL;
    bus.in_tag    = 4'hF;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_tag",   bus.out_tag,   0);
    check("rst_out_zero",  bus.out_zero,  0);
    check("rst_in_ready",  bus.in_ready,  1);
    @(posedge clk);
    #1;

    // Hand-computed values pinning the reference model.
    check("model_shl", ref_shift(SHL, 16'h0003, 8),  16'h0300);
    check("model_rol", ref_shift(ROL, 16'h8001, 1),  16'h0003);
    check("model_sra", ref_shift(SRA, 16'h8000, 4),  16'hF800);
    check("model_srl", ref_shift(SRL, 16'h8000, 15), 16'h0001);
    check("model_shl0", ref_shift(SHL, 16'h8000, 1), 16'h0000);
    check("model_rol15", ref_shift(ROL, 16'h0001, 15), 16'h8000);

    // First operation: latency and exact result.
    send(SHL, 16'h0003, 4'd8, 4'h5, acc);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("first_lat",  cyc - acc, SHW);
    check("first_data", bus.out_data, 16'h0300);
    check("first_zero", bus.out_zero, 0);
    check("first_tag",  bus.out_tag,  4'h5);
    @(posedge clk);
    #1;
    drain();

    // One op per mode, back to back.
    op4   = '{ROL, SRA, SRL, SHL};
    a4    = '{16'h8001, 16'h8000, 16'h8000, 16'h8000};
    amt4  = '{4'd1, 4'd4, 4'd15, 4'd1};
    want4 = '{16'h0003, 16'hF800, 16'h0001, 16'h0000};
    emit_q.delete();
    for (int i = 0; i < 4; i++) begin
      send(op4[i], a4[i], amt4[i], 4'(i + 1), acc);
      if (i == 0) acc0 = acc;
    end
    bus.in_valid = 1'b0;
    drain();
    check_back_to_back("modes", acc0, 4);
    if (emit_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("modes_data", emit_q[i].d, want4[i]);
      check("modes_zero", emit_q[3].z, 1);
    end

    // amt = 0 is identity in every mode.
    emit_q.delete();
    for (int i = 0; i < 4; i++) send(2'(i), 16'hA5C3, '0, 4'(i), acc);
    bus.in_valid = 1'b0;
    drain();
    check("amt0_count", emit_q.size(), 4);
    foreach (emit_q[i]) check("amt0_data", emit_q[i].d, 16'hA5C3);

    // Backpressure: 8 ops, consumer stalls from cycle 2 for 6 cycles.
    emit_q.delete();
    saw_full = 1'b0;
    fork
      begin
        for (int t = 0; t < 8; t++)
          send(2'(t), WIDTH'($urandom), SHW'($urandom_range(0, WIDTH - 1)), 4'(t), acc);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_fell", saw_full, 1);
    check("bp_count", emit_q.size(), 8);
    if (emit_q.size() == 8)
      for (int i = 0; i < 8; i++) check("bp_tag_order", emit_q[i].t, 4'(i));

    // Reset in the middle of three in-flight ops.
    emit_q.delete();
    for (int t = 0; t < 3; t++) send(SHL, 16'h1234, 4'd1, 4'(9 + t), acc);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("prerst_valid", bus.out_valid, 1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_data",  bus.out_data,  0);
    check("midrst_tag",   bus.out_tag,   0);
    check("midrst_zero",  bus.out_zero,  0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("postrst_in_ready", bus.in_ready, 1);
    check("postrst_emitted",  emit_q.size(), 0);

    // Throughput: 32 random ops with the consumer always ready.
    emit_q.delete();
    for (int i = 0; i < 32; i++) begin
      send(2'($urandom), WIDTH'($urandom), SHW'($urandom_range(0, WIDTH - 1)), 4'(i), acc);
      if (i == 0) acc0 = acc;
    end
    bus.in_valid = 1'b0;
    drain();
    check_back_to_back("thru", acc0, 32);

    // Random traffic: gaps on the input, random backpressure on the output.
    emit_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(2'($urandom), WIDTH'($urandom), SHW'($urandom_range(0, WIDTH - 1)), 4'(i), acc);
          repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("rand_count", emit_q.size(), 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
